// File: rtl/simd_issue_ctrl.sv
// Registered multi-beat issue controller for the SIMD AES core: vector ops issue one beat per lane group.
// Optional feature macro ILLEGAL_TRAP_EN: undefined opcodes issue a single trap beat with illegal=1.
module simd_issue_ctrl #(
    parameter int BITS           = 20,
    parameter int LANES          = 16,
    parameter int LANES_PER_BEAT = 4,
    localparam int NGROUPS       = LANES / LANES_PER_BEAT,
    localparam int GW            = (NGROUPS > 1) ? $clog2(NGROUPS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [BITS-1:0] Instruction,
    input  logic            stall,
    input  logic            flush,
    output logic            out_valid,
    output logic [1:0]      ALUControl,
    output logic            RegWrite,
    output logic            MemWrite,
    output logic            Branch,
    output logic            MemToReg,
    output logic            ALUScr,
    output logic            VecOp,
    output logic [GW-1:0]   LaneGroup,
    output logic            LastBeat,
    output logic            illegal
);

    typedef enum logic {IDLE, ISSUE} state_t;

    typedef struct packed {
        logic [1:0] alu;
        logic       rw;
        logic       mw;
        logic       br;
        logic       m2r;
        logic       src;
    } ctrl_t;

    localparam logic [4:0] OP_NOP   = 5'b00000;
    localparam logic [4:0] OP_ADD   = 5'b00001;
    localparam logic [4:0] OP_XOR   = 5'b00010;
    localparam logic [4:0] OP_ROT   = 5'b00011;
    localparam logic [4:0] OP_SBOX  = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_LOAD  = 5'b00110;
    localparam logic [4:0] OP_STORE = 5'b00111;
    localparam logic [4:0] OP_BEQ   = 5'b01000;

    localparam logic [GW-1:0]   LAST_GROUP = GW'(NGROUPS - 1);
    localparam logic [BITS-1:0] USED_MASK  = {5'b11111, {(BITS-5){1'b0}}} | (BITS'(1) << 14);

    state_t        state_q, state_d;
    ctrl_t         ctrl_q, ctrl_d, dec_ctrl;
    logic          vec_q, vec_d, dec_vec;
    logic [GW-1:0] group_q, group_d;
    logic          last_q, last_d, dec_last;
    logic          ill_q, ill_d, dec_illegal;
    logic          dec_legal;
    logic          accept;
    logic [4:0]    op;
    logic          rd_type;
    logic          unused_instr_bits;

    assign op                = Instruction[BITS-1:BITS-5];
    assign rd_type           = Instruction[14];
    assign unused_instr_bits = |(Instruction & ~USED_MASK);

    always_comb begin
        dec_ctrl    = '0;
        dec_legal   = 1'b1;
        dec_illegal = 1'b0;
        dec_vec     = rd_type;
        unique case (op)
            OP_NOP:   dec_ctrl = '{alu: 2'b00, rw: 1'b0, mw: 1'b0, br: 1'b0, m2r: 1'b0, src: 1'b0};
            OP_ADD:   dec_ctrl = '{alu: 2'b00, rw: 1'b1, mw: 1'b0, br: 1'b0, m2r: 1'b0, src: 1'b0};
            OP_XOR:   dec_ctrl = '{alu: 2'b01, rw: 1'b1, mw: 1'b0, br: 1'b0, m2r: 1'b0, src: 1'b0};
            OP_ROT:   dec_ctrl = '{alu: 2'b10, rw: 1'b1, mw: 1'b0, br: 1'b0, m2r: 1'b0, src: 1'b1};
            OP_SBOX:  dec_ctrl = '{alu: 2'b11, rw: 1'b1, mw: 1'b0, br: 1'b0, m2r: 1'b0, src: 1'b0};
            OP_ADDI:  dec_ctrl = '{alu: 2'b00, rw: 1'b1, mw: 1'b0, br: 1'b0, m2r: 1'b0, src: 1'b1};
            OP_LOAD:  dec_ctrl = '{alu: 2'b00, rw: 1'b1, mw: 1'b0, br: 1'b0, m2r: 1'b1, src: 1'b1};
            OP_STORE: dec_ctrl = '{alu: 2'b00, rw: 1'b0, mw: 1'b1, br: 1'b0, m2r: 1'b0, src: 1'b1};
            OP_BEQ:   dec_ctrl = '{alu: 2'b00, rw: 1'b0, mw: 1'b0, br: 1'b1, m2r: 1'b0, src: 1'b0};
            default:  dec_legal = 1'b0;
        endcase
        // A branch has no meaning across lane groups, so a vector BEQ is treated as undefined
        if (op == OP_BEQ && rd_type) begin
            dec_legal = 1'b0;
        end
        if (!dec_legal) begin
            dec_ctrl = '0;
        end
`ifdef ILLEGAL_TRAP_EN
        if (!dec_legal) begin
            dec_vec     = 1'b0;
            dec_illegal = 1'b1;
        end
`endif
        dec_last = !dec_vec || (NGROUPS == 1);
    end

    assign instr_ready = !rst && !stall && ((state_q == IDLE) || last_q);
    assign accept      = instr_valid && instr_ready;

    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        vec_d   = vec_q;
        group_d = group_q;
        last_d  = last_q;
        ill_d   = ill_q;
        if (flush) begin
            state_d = IDLE;
            ctrl_d  = '0;
            vec_d   = 1'b0;
            group_d = '0;
            last_d  = 1'b0;
            ill_d   = 1'b0;
        end else if (!stall) begin
            if (accept) begin
                state_d = ISSUE;
                ctrl_d  = dec_ctrl;
                vec_d   = dec_vec;
                group_d = '0;
                last_d  = dec_last;
                ill_d   = dec_illegal;
            end else if (state_q == ISSUE) begin
                if (last_q) begin
                    state_d = IDLE;
                    ctrl_d  = '0;
                    vec_d   = 1'b0;
                    group_d = '0;
                    last_d  = 1'b0;
                    ill_d   = 1'b0;
                end else begin
                    group_d = group_q + GW'(1);
                    last_d  = ((group_q + GW'(1)) == LAST_GROUP);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ctrl_q  <= '0;
            vec_q   <= 1'b0;
            group_q <= '0;
            last_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            vec_q   <= vec_d;
            group_q <= group_d;
            last_q  <= last_d;
            ill_q   <= ill_d;
        end
    end

    assign out_valid  = (state_q == ISSUE);
    assign ALUControl = ctrl_q.alu;
    assign RegWrite   = ctrl_q.rw;
    assign MemWrite   = ctrl_q.mw;
    assign Branch     = ctrl_q.br;
    assign MemToReg   = ctrl_q.m2r;
    assign ALUScr     = ctrl_q.src;
    assign VecOp      = vec_q;
    assign LaneGroup  = group_q;
    assign LastBeat   = last_q;
    assign illegal    = ill_q;

endmodule

// File: tb/tb_simd_issue_ctrl.sv
// Self-checking bench for simd_issue_ctrl: directed scenarios then random traffic against a beat-queue model.
module tb_simd_issue_ctrl;

    localparam int BITS = 20;
    localparam int GW   = 2;
    localparam int NB   = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            instr_valid;
    logic            instr_ready;
    logic [BITS-1:0] Instruction;
    logic            stall;
    logic            flush;
    logic            out_valid;
    logic [1:0]      ALUControl;
    logic            RegWrite, MemWrite, Branch, MemToReg, ALUScr, VecOp;
    logic [GW-1:0]   LaneGroup;
    logic            LastBeat;
    logic            illegal;

    int total_checks = 0;
    int pass_checks  = 0;

    typedef struct packed {
        logic       ov;
        logic [1:0] alu;
        logic       rw, mw, br, m2r, src, vec;
        logic [1:0] lg;
        logic       last;
        logic       ill;
    } beat_t;

    // Remaining beats of the instruction in flight; entry 0 is what the outputs should show now
    beat_t beats[$];

    simd_issue_ctrl dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .Instruction(Instruction), .stall(stall), .flush(flush), .out_valid(out_valid),
        .ALUControl(ALUControl), .RegWrite(RegWrite), .MemWrite(MemWrite), .Branch(Branch),
        .MemToReg(MemToReg), .ALUScr(ALUScr), .VecOp(VecOp), .LaneGroup(LaneGroup),
        .LastBeat(LastBeat), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic pushInstr(input logic [BITS-1:0] w);
        logic [4:0] op;
        logic       vec;
        logic [6:0] c;
        logic       bad;
        beat_t      b;
        int         n;
        op  = w[19:15];
        vec = w[14];
        bad = 1'b0;
        case (op)
            5'd0: c = 7'b00_00000;
            5'd1: c = 7'b00_10000;
            5'd2: c = 7'b01_10000;
            5'd3: c = 7'b10_10001;
            5'd4: c = 7'b11_10000;
            5'd5: c = 7'b00_10001;
            5'd6: c = 7'b00_10011;
            5'd7: c = 7'b00_01001;
            5'd8: c = 7'b00_00100;
            default: begin c = '0; bad = 1'b1; end
        endcase
        if (op == 5'd8 && vec) begin
            c   = '0;
            bad = 1'b1;
        end
`ifdef ILLEGAL_TRAP_EN
        if (bad) begin
            b = '{ov: 1'b1, alu: 2'b00, rw: 1'b0, mw: 1'b0, br: 1'b0, m2r: 1'b0,
                  src: 1'b0, vec: 1'b0, lg: 2'd0, last: 1'b1, ill: 1'b1};
            beats.push_back(b);
            return;
        end
`endif
        n = vec ? NB : 1;
        for (int i = 0; i < n; i++) begin
            b = '{ov: 1'b1, alu: c[6:5], rw: c[4], mw: c[3], br: c[2], m2r: c[1],
                  src: c[0], vec: vec, lg: 2'(i), last: (i == n - 1), ill: 1'b0};
            beats.push_back(b);
        end
    endtask

    task automatic checkOutput(input string tag, output logic exp_ready);
        beat_t exp_b;
        beat_t obs_b;
        exp_b     = (beats.size() == 0) ? beat_t'('0) : beats[0];
        exp_ready = !rst && !stall && (beats.size() <= 1);
        obs_b = '{ov: out_valid, alu: ALUControl, rw: RegWrite, mw: MemWrite, br: Branch,
                  m2r: MemToReg, src: ALUScr, vec: VecOp, lg: LaneGroup, last: LastBeat, ill: illegal};
        total_checks++;
        assert (obs_b === exp_b) pass_checks++;
        else $error("[TB] FAIL %s outputs: observed %b expected %b", tag, obs_b, exp_b);
        total_checks++;
        assert (instr_ready === exp_ready) pass_checks++;
        else $error("[TB] FAIL %s instr_ready: observed %b expected %b", tag, instr_ready, exp_ready);
    endtask

    // One clock cycle: drive inputs, check the registered state, then advance the model with the edge
    task automatic applyStimulus(input string tag, input logic r, input logic v,
                                 input logic [BITS-1:0] w, input logic s, input logic f);
        logic exp_ready;
        rst         = r;
        instr_valid = v;
        Instruction = w;
        stall       = s;
        flush       = f;
        #1;
        checkOutput(tag, exp_ready);
        if (r || f) begin
            beats.delete();
        end else if (!s) begin
            if (beats.size() > 0) void'(beats.pop_front());
            if (v && exp_ready) pushInstr(w);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0]      rop;
        logic [BITS-1:0] rw;
        rst = 1'b1; instr_valid = 1'b0; Instruction = '0; stall = 1'b0; flush = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus("reset0", 1, 0, 20'h00000, 0, 0);
        applyStimulus("reset1", 1, 1, 20'h08000, 0, 0);
        applyStimulus("idle", 0, 0, 20'h00000, 0, 0);

        applyStimulus("add_offer", 0, 1, 20'h08000, 0, 0);
        applyStimulus("add_beat", 0, 0, 20'h00000, 0, 0);
        applyStimulus("add_done", 0, 0, 20'h00000, 0, 0);

        applyStimulus("xor_offer", 0, 1, 20'h14000, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus("xor_beat", 0, 0, 20'h00000, 0, 0);

        applyStimulus("stall_offer", 0, 1, 20'h14000, 0, 0);
        applyStimulus("stall_b0", 0, 0, 20'h00000, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus("stall_hold", 0, 1, 20'h08000, 1, 0);
        for (int i = 0; i < 4; i++) applyStimulus("stall_rest", 0, 0, 20'h00000, 0, 0);

        applyStimulus("flush_offer", 0, 1, 20'h14000, 0, 0);
        applyStimulus("flush_b0", 0, 0, 20'h00000, 0, 0);
        applyStimulus("flush_b1", 0, 0, 20'h00000, 0, 0);
        applyStimulus("flush_b2", 0, 1, 20'h08000, 0, 1);
        applyStimulus("flush_after", 0, 0, 20'h00000, 0, 0);

        applyStimulus("b2b_a", 0, 1, 20'h34000, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus("b2b_beats", 0, 0, 20'h00000, 0, 0);
        applyStimulus("b2b_next", 0, 1, 20'h38000, 0, 0);
        applyStimulus("b2b_tail", 0, 0, 20'h00000, 0, 0);

        applyStimulus("illegal_s", 0, 1, 20'hF8000, 0, 0);
        for (int i = 0; i < 2; i++) applyStimulus("illegal_s_b", 0, 0, 20'h00000, 0, 0);
        applyStimulus("illegal_v", 0, 1, 20'hFC000, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus("illegal_v_b", 0, 0, 20'h00000, 0, 0);
        applyStimulus("beq_vec", 0, 1, 20'h44000, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus("beq_vec_b", 0, 0, 20'h00000, 0, 0);

        applyStimulus("rst_mid_offer", 0, 1, 20'h24000, 0, 0);
        applyStimulus("rst_mid_b0", 0, 0, 20'h00000, 0, 0);
        applyStimulus("rst_mid", 1, 0, 20'h00000, 0, 0);
        applyStimulus("rst_mid_after", 0, 0, 20'h00000, 0, 0);

        for (int i = 0; i < 800; i++) begin
            rop = 5'($urandom_range(0, 10));
            if (rop > 5'd8) rop = 5'($urandom);
            rw = {rop, 1'($urandom), 14'($urandom)};
            applyStimulus("random",
                          ($urandom_range(0, 99) < 2),
                          ($urandom_range(0, 99) < 60),
                          rw,
                          ($urandom_range(0, 99) < 20),
                          ($urandom_range(0, 99) < 5));
        end

        $display("%0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end

endmodule
